// File: rtl/mem_stage_pkg.sv
// Shared types and widths for the memory stage and its data RAM.
package mem_stage_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Fields of one EX->MEM instruction, held while a multi-cycle access runs.
  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  wreg;
    logic              regw;
    logic              m2r;
    logic              mw;
    logic              mr;
  } mem_instr_t;

endpackage

// File: rtl/mem_stage_data_mem.sv
// Single-port synchronous data RAM: read-before-write, read data captured
// only when requested and cleared otherwise so non-loads write back zero.
module mem_stage_data_mem
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read capture sees the pre-write word on a simultaneous read and write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: multi-cycle data-memory access with upstream stall
// and the MEM->WB output register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_ALU_out,
  input  logic [DATA_W-1:0] i_Data_Write,
  input  logic [REG_W-1:0]  i_Write_Reg_M,
  input  logic              i_REGWrite_M,
  input  logic              i_MEMtoREG_M,
  input  logic              i_MEMWrite_M,
  input  logic              i_MEMRead_M,
  output logic [DATA_W-1:0] o_Read_Data_W,
  output logic [DATA_W-1:0] o_ALU_out_W,
  output logic [REG_W-1:0]  o_Write_Reg_W,
  output logic              o_REGWrite_W,
  output logic              o_MEMtoREG_W,
  output logic              o_Stall_M
);

  localparam bit               MULTI     = (MEM_LAT > 1);
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  mem_instr_t       in_c, held, cur_c;
  logic             mem_op_c, complete_c, capture_c, stall_c;
  logic             we_c, re_c;

  assign in_c = '{alu:  i_ALU_out,    data: i_Data_Write, wreg: i_Write_Reg_M,
                  regw: i_REGWrite_M, m2r:  i_MEMtoREG_M,
                  mw:   i_MEMWrite_M, mr:   i_MEMRead_M};

  // A running access works only from its held copy.
  assign cur_c    = (state == BUSY) ? held : in_c;
  assign mem_op_c = i_MEMRead_M | i_MEMWrite_M;

  // State and latency counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state, completion and stall decode.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    complete_c = 1'b0;
    capture_c  = 1'b0;
    stall_c    = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_op_c && MULTI) begin
          state_n   = BUSY;
          cnt_n     = CNT_START;
          capture_c = 1'b1;
          stall_c   = 1'b1;
        end else begin
          complete_c = 1'b1;
        end
      end
      BUSY: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_LAST) begin
          state_n    = IDLE;
          complete_c = 1'b1;
        end else begin
          stall_c = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign o_Stall_M = stall_c;

  // Hold the accepted instruction for the duration of the access.
  always_ff @(posedge clk) begin
    if (rst) begin
      held <= '0;
    end else if (capture_c) begin
      held <= in_c;
    end
  end

  // MEM->WB register: instruction fields on completion, bubble otherwise.
  always_ff @(posedge clk) begin
    if (rst || !complete_c) begin
      o_ALU_out_W   <= '0;
      o_Write_Reg_W <= '0;
      o_REGWrite_W  <= 1'b0;
      o_MEMtoREG_W  <= 1'b0;
    end else begin
      o_ALU_out_W   <= cur_c.alu;
      o_Write_Reg_W <= cur_c.wreg;
      o_REGWrite_W  <= cur_c.regw;
      o_MEMtoREG_W  <= cur_c.m2r;
    end
  end

  assign we_c = complete_c & cur_c.mw & ~rst;
  assign re_c = complete_c & cur_c.mr;

  mem_stage_data_mem #(
    .ADDR_W(ADDR_W)
  ) u_data_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (we_c),
    .re    (re_c),
    .addr  (cur_c.alu[ADDR_W-1:0]),
    .wdata (cur_c.data),
    .rdata (o_Read_Data_W)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: three instances (latency 2, 3, 1) checked
// against a per-instruction memory model.
module tb_mem_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [15:0] alu_in  [3];
  logic [15:0] dat_in  [3];
  logic [4:0]  wreg_in [3];
  logic        regw_in [3];
  logic        m2r_in  [3];
  logic        mw_in   [3];
  logic        mr_in   [3];

  logic [15:0] rd_o    [3];
  logic [15:0] alu_o   [3];
  logic [4:0]  wreg_o  [3];
  logic        regw_o  [3];
  logic        m2r_o   [3];
  logic        stall_o [3];

  logic [15:0] mdl [3][256];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 2 : ((g == 1) ? 3 : 1);
    mem_stage #(.ADDR_W(8), .MEM_LAT(L)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .i_ALU_out     (alu_in[g]),
      .i_Data_Write  (dat_in[g]),
      .i_Write_Reg_M (wreg_in[g]),
      .i_REGWrite_M  (regw_in[g]),
      .i_MEMtoREG_M  (m2r_in[g]),
      .i_MEMWrite_M  (mw_in[g]),
      .i_MEMRead_M   (mr_in[g]),
      .o_Read_Data_W (rd_o[g]),
      .o_ALU_out_W   (alu_o[g]),
      .o_Write_Reg_W (wreg_o[g]),
      .o_REGWrite_W  (regw_o[g]),
      .o_MEMtoREG_W  (m2r_o[g]),
      .o_Stall_M     (stall_o[g])
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 3 : 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input int d, input string tag, input logic [15:0] rd,
                            input logic [15:0] alu, input logic [4:0] wreg,
                            input logic regw, input logic m2r);
    check($sformatf("d%0d.%s.rd", d, tag),   32'(rd_o[d]),   32'(rd));
    check($sformatf("d%0d.%s.alu", d, tag),  32'(alu_o[d]),  32'(alu));
    check($sformatf("d%0d.%s.wreg", d, tag), 32'(wreg_o[d]), 32'(wreg));
    check($sformatf("d%0d.%s.regw", d, tag), 32'(regw_o[d]), 32'(regw));
    check($sformatf("d%0d.%s.m2r", d, tag),  32'(m2r_o[d]),  32'(m2r));
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 3; k++) begin
      alu_in[k] = '0; dat_in[k] = '0; wreg_in[k] = '0;
      regw_in[k] = 1'b0; m2r_in[k] = 1'b0; mw_in[k] = 1'b0; mr_in[k] = 1'b0;
    end
  endtask

  // Present one instruction to DUT d, hold it until it completes, check every cycle.
  task automatic issue(input int d, input logic [15:0] alu, input logic [15:0] data,
                       input logic [4:0] wreg, input logic regw, input logic m2r,
                       input logic mw, input logic mr);
    int          lat;
    int          a;
    logic [15:0] exp_rd;
    lat = lat_of(d);
    a   = int'(alu[7:0]);
    @(negedge clk);
    clear_inputs();
    alu_in[d] = alu; dat_in[d] = data; wreg_in[d] = wreg;
    regw_in[d] = regw; m2r_in[d] = m2r; mw_in[d] = mw; mr_in[d] = mr;
    exp_rd = mr ? mdl[d][a] : 16'h0;
    if ((mw || mr) && lat > 1) begin
      for (int k = 0; k < lat - 1; k++) begin
        #1 check($sformatf("d%0d.stall_hi", d), 32'(stall_o[d]), 32'(1));
        @(posedge clk);
        #1 check_outs(d, "bubble", 16'h0, 16'h0, 5'h0, 1'b0, 1'b0);
        @(negedge clk);
      end
    end
    #1 check($sformatf("d%0d.stall_lo", d), 32'(stall_o[d]), 32'(0));
    @(posedge clk);
    #1 check_outs(d, "done", exp_rd, alu, wreg, regw, m2r);
    if (mw) mdl[d][a] = data;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check_outs(d, "reset", 16'h0, 16'h0, 5'h0, 1'b0, 1'b0);
      check($sformatf("d%0d.reset_stall", d), 32'(stall_o[d]), 32'(0));
    end
    @(negedge clk);
    rst = 1'b0;

    // Give every word a known value.
    for (int d = 0; d < 3; d++)
      for (int a = 0; a < 256; a++)
        issue(d, 16'(a), 16'($urandom), 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // ALU pass-through, latency 2.
    issue(0, 16'h1234, 16'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    check("alu_const", 32'(alu_o[0]), 32'h1234);

    // Latency 3: store then load back-to-back, aliasing, read+write.
    issue(1, 16'h0010, 16'hBEEF, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    issue(1, 16'h0010, 16'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    check("beef_const", 32'(rd_o[1]), 32'hBEEF);
    issue(1, 16'h0110, 16'hC0DE, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    issue(1, 16'h0010, 16'h0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    check("alias_const", 32'(rd_o[1]), 32'hC0DE);
    issue(1, 16'h0020, 16'h1111, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    issue(1, 16'h0020, 16'h2222, 5'd6, 1'b1, 1'b1, 1'b1, 1'b1);
    check("rw_old_const", 32'(rd_o[1]), 32'h1111);
    issue(1, 16'h0020, 16'h0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    check("rw_new_const", 32'(rd_o[1]), 32'h2222);

    // Reset in the second cycle of a latency-3 store aborts it.
    issue(1, 16'h0030, 16'h5555, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    clear_inputs();
    alu_in[1] = 16'h0030; dat_in[1] = 16'hAAAA; mw_in[1] = 1'b1;
    #1 check("abort.stall_first", 32'(stall_o[1]), 32'(1));
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(posedge clk);
    #1 check_outs(1, "abort", 16'h0, 16'h0, 5'h0, 1'b0, 1'b0);
    check("abort.stall", 32'(stall_o[1]), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    issue(1, 16'h0030, 16'h0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);
    check("abort_mem_const", 32'(rd_o[1]), 32'h5555);

    // Latency 1: alternating stores and loads, never stalls.
    for (int i = 0; i < 16; i++) begin
      logic [15:0] adr;
      adr = 16'($urandom_range(0, 7));
      issue(2, adr, 16'($urandom), 5'(i), 1'b1, 1'b0, 1'b1, 1'b0);
      issue(2, adr, 16'h0, 5'(i), 1'b1, 1'b1, 1'b0, 1'b1);
    end

    // Fully random instruction mix on every instance.
    for (int i = 0; i < 150; i++)
      for (int d = 0; d < 3; d++)
        issue(d, 16'($urandom), 16'($urandom), 5'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
